// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU pipeline port and debug/loader port share one
// memory bus through an IDLE/BUSY/RESP handshake with starvation guard and timeout.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_done,
   output logic        err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          err_q, err_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;
   logic [31:0]   dbg_rdata_q, dbg_rdata_d;
   logic          grant_dbg;

   // Debug port wins when alone or when the CPU has starved it long enough.
   assign grant_dbg = dbg_req & (~cpu_req | (starve_q == STARVE_LIM));

   // Next-state: arbitration in IDLE, wait/ack/timeout in BUSY, one-cycle RESP.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      starve_d    = starve_q;
      wait_d      = wait_q;
      err_d       = err_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req | dbg_req) begin
               owner_d = grant_dbg;
               we_d    = grant_dbg ? dbg_we    : cpu_we;
               addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
               wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
               wait_d  = '0;
               err_d   = 1'b0;
               state_d = BUSY;
               if (grant_dbg) begin
                  starve_d = '0;
               end else if (dbg_req && starve_q != STARVE_LIM) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               if (!we_q) begin
                  if (owner_q) dbg_rdata_d = mem_rdata;
                  else         cpu_rdata_d = mem_rdata;
               end
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wait_q == WAIT_LIM) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         starve_q    <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         starve_q    <= starve_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign mem_en    = (state_q == BUSY);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_done  = (state_q == RESP) & ~owner_q;
   assign dbg_done  = (state_q == RESP) & owner_q;
   assign err       = (state_q == RESP) & err_q;
   assign cpu_stall = cpu_req & ~cpu_done;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, starvation order, wait states,
// timeout, mid-access reset and request withdrawal.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_done, cpu_stall;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        dbg_done, err;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int          n_chk;
   int          n_pass;
   int          ack_wait;
   int          busy_cnt;
   int          dual;
   logic [31:0] rd_val;

   mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_done  (cpu_done),
      .cpu_stall (cpu_stall),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata),
      .dbg_done  (dbg_done),
      .err       (err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance to the next falling edge and play the memory side for the
   // following rising edge: ack once more than ack_wait BUSY cycles seen.
   task automatic step();
      @(negedge clk);
      if (cpu_done && dbg_done) dual++;
      if (mem_en) begin
         busy_cnt++;
         mem_ack = (ack_wait >= 0) && (busy_cnt > ack_wait);
      end else begin
         busy_cnt = 0;
         mem_ack  = 1'b0;
      end
      mem_rdata = rd_val;
   endtask

   task automatic run(input bit use_dbg, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input int aw, output int lat, output int stall_n,
                      output int busy_n, output int busy_ok);
      lat      = -1;
      stall_n  = 0;
      busy_n   = 0;
      busy_ok  = 0;
      ack_wait = aw;
      if (use_dbg) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
         cpu_req = 1'b0;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
         dbg_req = 1'b0;
      end
      for (int i = 1; i <= 40; i++) begin
         #1;
         if (cpu_stall) stall_n++;
         step();
         if (mem_en) begin
            busy_n++;
            if (mem_we == we && mem_addr == a && mem_wdata == d) busy_ok++;
         end
         if (use_dbg ? dbg_done : cpu_done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic drop();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      step();
      check("done_one_cycle", 32'({cpu_done, dbg_done}), 32'd0);
   endtask

   initial begin
      int lat, stall_n, busy_n, busy_ok, ng;
      logic [9:0] ord;
      n_chk = 0; n_pass = 0; dual = 0; busy_cnt = 0;
      ack_wait = 0; rd_val = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      mem_rdata = '0; mem_ack = 0;
      reset = 1'b1;
      #1 reset = 1'b0;
      step();
      step();
      check("rst_cpu_done", 32'(cpu_done), 32'd0);
      check("rst_dbg_done", 32'(dbg_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_dbg_rdata", dbg_rdata, 32'd0);
      reset = 1'b1;
      step();

      // CPU read, zero-wait
      rd_val = 32'h1234_5678;
      run(0, 1'b0, 32'h1001_0000, 32'h0, 0, lat, stall_n, busy_n, busy_ok);
      check("rd_latency", lat, 2);
      check("rd_stall_cycles", stall_n, 2);
      check("rd_busy_addr", busy_ok, 1);
      check("rd_rdata", cpu_rdata, 32'h1234_5678);
      check("rd_err", 32'(err), 32'd0);
      check("rd_stall_at_done", 32'(cpu_stall), 32'd0);
      check("rd_mem_en_resp", 32'(mem_en), 32'd0);
      drop();

      // DBG write with three wait cycles
      rd_val = 32'hFFFF_FFFF;
      run(1, 1'b1, 32'h4000_0010, 32'hCAFE_0001, 3,
          lat, stall_n, busy_n, busy_ok);
      check("wr_latency", lat, 5);
      check("wr_busy_cycles", busy_n, 4);
      check("wr_busy_stable", busy_ok, 4);
      check("wr_err", 32'(err), 32'd0);
      check("wr_dbg_rdata", dbg_rdata, 32'd0);
      check("wr_mem_we_resp", 32'(mem_we), 32'd0);
      check("wr_addr_hold", mem_addr, 32'h4000_0010);
      check("wr_wdata_hold", mem_wdata, 32'hCAFE_0001);
      drop();

      // CPU read that never gets an ack
      rd_val = 32'hDEAD_BEEF;
      run(0, 1'b0, 32'h1001_0004, 32'h0, -1, lat, stall_n, busy_n, busy_ok);
      check("to_latency", lat, 17);
      check("to_busy_cycles", busy_n, 16);
      check("to_err", 32'(err), 32'd1);
      check("to_rdata_kept", cpu_rdata, 32'h1234_5678);
      drop();
      check("to_err_clear", 32'(err), 32'd0);
      rd_val = 32'h0BAD_F00D;
      run(0, 1'b0, 32'h1001_0008, 32'h0, 0, lat, stall_n, busy_n, busy_ok);
      check("after_to_latency", lat, 2);
      check("after_to_rdata", cpu_rdata, 32'h0BAD_F00D);
      check("after_to_err", 32'(err), 32'd0);
      drop();

      // Both ports requesting continuously
      ack_wait = 0;
      cpu_we = 0; dbg_we = 0;
      cpu_req = 1; dbg_req = 1;
      ord = '0; ng = 0; dual = 0;
      for (int i = 0; i < 60 && ng < 10; i++) begin
         step();
         if (cpu_done || dbg_done) begin
            ord = {ord[8:0], dbg_done};
            ng++;
         end
      end
      check("grant_count", ng, 10);
      check("grant_order", 32'(ord), 32'h021);
      check("no_dual_done", dual, 0);
      drop();

      // Reset during the second BUSY cycle
      ack_wait = -1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0020;
      step();
      step();
      check("rstb_busy", 32'(mem_en), 32'd1);
      reset = 1'b0;
      cpu_req = 1'b0;
      #1;
      check("rstb_mem_en", 32'(mem_en), 32'd0);
      check("rstb_cpu_done", 32'(cpu_done), 32'd0);
      step();
      check("rstb_no_done", 32'({cpu_done, dbg_done}), 32'd0);
      check("rstb_rdata", cpu_rdata, 32'd0);
      reset = 1'b1;
      rd_val = 32'h5555_AAAA;
      run(0, 1'b0, 32'h1001_0024, 32'h0, 0, lat, stall_n, busy_n, busy_ok);
      check("rstb_latency", lat, 2);
      check("rstb_new_rdata", cpu_rdata, 32'h5555_AAAA);
      drop();

      // Request withdrawn in BUSY, re-raised in RESP
      ack_wait = 1;
      rd_val = 32'h1111_2222;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0030;
      step();
      check("wd_busy1", 32'(mem_en), 32'd1);
      cpu_req = 0;
      step();
      check("wd_busy2", 32'(mem_en), 32'd1);
      step();
      check("wd_done", 32'(cpu_done), 32'd1);
      check("wd_rdata", cpu_rdata, 32'h1111_2222);
      ack_wait = 0;
      rd_val = 32'h3333_4444;
      cpu_req = 1; cpu_addr = 32'h1001_0034;
      step();
      check("wd_idle_after_resp", 32'(mem_en), 32'd0);
      check("wd_no_done_idle", 32'(cpu_done), 32'd0);
      step();
      check("wd_rearb_busy", 32'(mem_en), 32'd1);
      check("wd_rearb_addr", mem_addr, 32'h1001_0034);
      step();
      check("wd_rearb_done", 32'(cpu_done), 32'd1);
      check("wd_rearb_rdata", cpu_rdata, 32'h3333_4444);
      drop();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
